// File: rtl/shadow_stack_monitor.sv
// Return-address shadow stack for the execute stage: pushes on calls, checks returns,
// and raises a latched violation with a halt handshake until software clears it.
module shadow_stack_monitor #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned VLEN  = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     resolve_valid_i,
   input  logic                     is_call_i,
   input  logic                     is_return_i,
   input  logic [VLEN-1:0]          pc_i,
   input  logic                     is_compressed_i,
   input  logic [VLEN-1:0]          target_i,
   input  logic                     check_en_i,
   input  logic                     flush_i,
   input  logic                     clear_i,
   input  logic                     halt_ack_i,
   output logic                     violation_o,
   output logic [VLEN-1:0]          violation_pc_o,
   output logic [CNT_W-1:0]         violation_cnt_o,
   output logic                     halt_req_o,
   output logic                     locked_o,
   output logic [$clog2(DEPTH):0]   depth_o,
   output logic                     overflow_o
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned DEP_W  = PTR_W + 1;
   localparam int unsigned LOST_W = 16;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_HALT_REQ = 2'd1,
      S_LOCKED   = 2'd2
   } state_t;

   state_t             state_q;
   logic [VLEN-1:0]    stack_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [DEP_W-1:0]   depth_q;
   logic [LOST_W-1:0]  lost_cnt_q;

   logic               event_c;
   logic               push_c;
   logic               viol_c;
   logic               ovf_set_c;
   logic               full_after_pop_c;
   logic [VLEN-1:0]    ret_addr_c;
   logic [VLEN-1:0]    top_c;
   logic [PTR_W-1:0]   top_idx_c;
   logic [PTR_W-1:0]   pop_ptr_c;
   logic [DEP_W-1:0]   pop_depth_c;
   logic [PTR_W-1:0]   wr_ptr_n_c;
   logic [DEP_W-1:0]   depth_n_c;
   logic [LOST_W-1:0]  lost_n_c;

   // Event decode: pop/compare first, then push onto whatever the pop left behind.
   always_comb begin
      event_c          = resolve_valid_i & check_en_i & (state_q == S_RUN) & ~flush_i;
      ret_addr_c       = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));
      top_idx_c        = wr_ptr_q - PTR_W'(1);
      top_c            = stack_q[top_idx_c];
      pop_ptr_c        = wr_ptr_q;
      pop_depth_c      = depth_q;
      lost_n_c         = lost_cnt_q;
      viol_c           = 1'b0;
      push_c           = event_c & is_call_i;
      full_after_pop_c = 1'b0;
      ovf_set_c        = 1'b0;
      wr_ptr_n_c       = wr_ptr_q;
      depth_n_c        = depth_q;

      if (event_c && is_return_i) begin
         if (depth_q != '0) begin
            pop_ptr_c   = top_idx_c;
            pop_depth_c = depth_q - DEP_W'(1);
            // Bit 0 is ignored on both sides; JALR clears it in the target anyway.
            viol_c      = |((top_c ^ target_i) >> 1);
         end else if (lost_cnt_q != '0) begin
            lost_n_c = lost_cnt_q - LOST_W'(1);
         end else begin
            viol_c = 1'b1;
         end
      end

      full_after_pop_c = (pop_depth_c == DEP_W'(DEPTH));
      wr_ptr_n_c       = pop_ptr_c;
      depth_n_c        = pop_depth_c;

      if (push_c) begin
         wr_ptr_n_c = pop_ptr_c + PTR_W'(1);
         if (full_after_pop_c) begin
            ovf_set_c = 1'b1;
            if (lost_n_c != {LOST_W{1'b1}}) begin
               lost_n_c = lost_n_c + LOST_W'(1);
            end
         end else begin
            depth_n_c = pop_depth_c + DEP_W'(1);
         end
      end
   end

   // Control state, pointers and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= S_RUN;
         wr_ptr_q        <= '0;
         depth_q         <= '0;
         lost_cnt_q      <= '0;
         violation_o     <= 1'b0;
         violation_pc_o  <= '0;
         violation_cnt_o <= '0;
         halt_req_o      <= 1'b0;
         locked_o        <= 1'b0;
         overflow_o      <= 1'b0;
      end else begin
         violation_o <= viol_c;
         if (viol_c) begin
            violation_pc_o <= pc_i;
            if (violation_cnt_o != {CNT_W{1'b1}}) begin
               violation_cnt_o <= violation_cnt_o + CNT_W'(1);
            end
         end

         if (flush_i) begin
            wr_ptr_q   <= '0;
            depth_q    <= '0;
            lost_cnt_q <= '0;
            overflow_o <= 1'b0;
         end else begin
            wr_ptr_q   <= wr_ptr_n_c;
            depth_q    <= depth_n_c;
            lost_cnt_q <= lost_n_c;
            if (ovf_set_c) begin
               overflow_o <= 1'b1;
            end
         end

         case (state_q)
            S_RUN: begin
               if (viol_c) begin
                  state_q    <= S_HALT_REQ;
                  halt_req_o <= 1'b1;
               end
            end
            S_HALT_REQ: begin
               if (halt_ack_i) begin
                  state_q    <= S_LOCKED;
                  halt_req_o <= 1'b0;
                  locked_o   <= 1'b1;
               end
            end
            S_LOCKED: begin
               if (clear_i) begin
                  state_q  <= S_RUN;
                  locked_o <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_RUN;
               halt_req_o <= 1'b0;
               locked_o   <= 1'b0;
            end
         endcase
      end
   end

   // Stack storage needs no reset; entries are only read while depth is non-zero.
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         stack_q[pop_ptr_c] <= ret_addr_c;
      end
   end

   assign depth_o = depth_q;

endmodule
